// File: rtl/multiword_add_arbiter.sv
// Multiword adder shared by four requesters.
// A round-robin arbiter picks one requester in IDLE and captures its operands.
// A single 16-bit carry-select adder then processes one beat per cycle,
// least significant beat first, chaining the carry through a register.
// The result is held in DONE until the consumer takes it.
//
// state | meaning
// IDLE  | no work; grant the next requester in round-robin order
// ADD   | one 16-bit beat per cycle, beat index k
// DONE  | result valid, waiting for rsp_ready

// 16-bit carry-select adder: the low nibble ripples, and each upper nibble is
// precomputed for both carry-in values, then selected by the incoming carry.
module Carry_Select_Adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [4:0] blk0;
  logic [4:0] blk_c0 [1:3];
  logic [4:0] blk_c1 [1:3];
  logic [4:0] carry;

  // Low nibble uses the real carry-in; upper nibbles compute both options.
  always_comb begin
    blk0 = 5'(a[3:0]) + 5'(b[3:0]) + 5'(cin);
    for (int n = 1; n < 4; n++) begin
      blk_c0[n] = 5'(a[4*n +: 4]) + 5'(b[4*n +: 4]);
      blk_c1[n] = 5'(a[4*n +: 4]) + 5'(b[4*n +: 4]) + 5'd1;
    end
  end

  // Select each upper nibble by the carry out of the nibble below it.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    sum[3:0] = blk0[3:0];
    carry[1] = blk0[4];
    for (int n = 1; n < 4; n++) begin
      if (carry[n]) begin
        sum[4*n +: 4] = blk_c1[n][3:0];
        carry[n+1]    = blk_c1[n][4];
      end else begin
        sum[4*n +: 4] = blk_c0[n][3:0];
        carry[n+1]    = blk_c0[n][4];
      end
    end
    cout = carry[4];
  end

endmodule

module multiword_add_arbiter #(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req_valid,
  output logic [3:0]              req_ready,
  input  logic [4*16*WORDS-1:0]   req_a,
  input  logic [4*16*WORDS-1:0]   req_b,
  input  logic [3:0]              req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_id,
  output logic [16*WORDS-1:0]     rsp_sum,
  output logic                    rsp_cout,
  output logic                    busy
);

  localparam int         W      = 16 * WORDS;
  localparam logic [2:0] K_LAST = 3'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;

  logic [1:0]   ptr;
  logic [2:0]   k;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         cin_q;
  logic         carry_q;

  logic         grant_any;
  logic [1:0]   grant_idx;
  logic [1:0]   cand;

  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic         sel_cin;

  logic [15:0]  beat_a;
  logic [15:0]  beat_b;
  logic         beat_cin;
  logic [15:0]  beat_sum;
  logic         beat_cout;

  // Round-robin search starting just after the last winner, wrapping to it last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr;
    cand      = ptr;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant strobe only in IDLE and never while reset is applied.
  always_comb begin
    req_ready = 4'b0000;
    if (state == IDLE && !rst && grant_any) begin
      req_ready = 4'b0001 << grant_idx;
    end
  end

  // Operand mux for the winning requester; only sampled on the grant edge.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_cin = req_cin[i];
      end
    end
  end

  // Current beat slices; beat 0 takes the captured carry-in, later beats chain.
  always_comb begin
    beat_a   = 16'(a_q >> {k, 4'b0000});
    beat_b   = 16'(b_q >> {k, 4'b0000});
    beat_cin = (k == 3'd0) ? cin_q : carry_q;
  end

  Carry_Select_Adder u_csa (
    .a    (beat_a),
    .b    (beat_b),
    .cin  (beat_cin),
    .sum  (beat_sum),
    .cout (beat_cout)
  );

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_any) state_next = ADD;
      ADD:  if (k == K_LAST) state_next = DONE;
      DONE: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, beat accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 2'd3;
      k        <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            cin_q  <= sel_cin;
            ptr    <= grant_idx;
            rsp_id <= grant_idx;
            k      <= 3'd0;
          end
        end
        ADD: begin
          rsp_sum[{k, 4'b0000} +: 16] <= beat_sum;
          carry_q <= beat_cout;
          if (k == K_LAST) begin
            rsp_cout <= beat_cout;
            k        <= 3'd0;
          end else begin
            k <= k + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_multiword_add_arbiter.sv
// Directed bench for multiword_add_arbiter with WORDS=4 (64-bit operands).
module tb_multiword_add_arbiter;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0]     req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  multiword_add_arbiter #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic wait_rsp(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_sum !== 64'h0) begin failures++; $display("FAIL reset_rsp_sum: got %h expected 0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin failures++; $display("FAIL reset_rsp_cout: got %b expected 0", rsp_cout); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL idle_no_req: busy %b req_ready %b expected 0 0000", busy, req_ready); end
  endtask

  task automatic test_latency();
    set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL lat_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy: got %b expected 1", busy); end
    for (int n = 1; n <= WORDS + 1; n++) begin
      if (n > 1) tick();
      checks++;
      if (rsp_valid !== (n == WORDS + 1)) begin
        failures++;
        $display("FAIL lat_rsp_valid_T+%0d: got %b expected %b", n, rsp_valid, (n == WORDS + 1));
      end
    end
    checks++; if (rsp_sum !== 64'h0) begin failures++; $display("FAIL lat_sum: got %h expected 0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b1) begin failures++; $display("FAIL lat_cout: got %b expected 1", rsp_cout); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL lat_id: got %0d expected 0", rsp_id); end
    handshake();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL lat_return_idle: rsp_valid %b busy %b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_carry_chain();
    bit ok;
    set_op(1, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0000, 1'b1);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL cc_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cc_timeout: rsp_valid got %b expected 1", rsp_valid); end
    checks++; if (rsp_sum !== 64'h0001_0000_0001_0000) begin failures++; $display("FAIL cc_sum: got %h expected 0001000000010000", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin failures++; $display("FAIL cc_cout: got %b expected 0", rsp_cout); end
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL cc_id: got %0d expected 1", rsp_id); end
    handshake();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] rr_a   [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [W-1:0] rr_b   [4] = '{64'h1, 64'h2, 64'h3, 64'h2};
    logic         rr_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] rr_sum [4] = '{64'h1111_1111_1111_1112, 64'h2222_2222_2222_2225, 64'h3333_3333_3333_3336, 64'h0000_0000_0000_0001};
    logic         rr_co  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int g_cyc [5];
    int g_id  [5];
    int r_cyc [5];
    int g_cnt = 0;
    int r_cnt = 0;
    int id;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, rr_a[i], rr_b[i], rr_c[i]);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 60 && g_cnt < 5; cyc++) begin
      if (req_ready !== 4'b0000) begin
        if ($countones(req_ready) != 1) begin
          checks++; failures++;
          $display("FAIL rr_onehot: got %b expected one-hot", req_ready);
        end
        id = 0;
        for (int b = 0; b < 4; b++) if (req_ready[b]) id = b;
        g_cyc[g_cnt] = cyc;
        g_id[g_cnt]  = id;
        g_cnt++;
      end
      if (rsp_valid === 1'b1 && r_cnt < 4) begin
        r_cyc[r_cnt] = cyc;
        checks++;
        if (rsp_id !== 2'(exp_order[r_cnt]) || rsp_sum !== rr_sum[exp_order[r_cnt]] || rsp_cout !== rr_co[exp_order[r_cnt]]) begin
          failures++;
          $display("FAIL rr_rsp_%0d: got id %0d sum %h cout %b expected id %0d sum %h cout %b", r_cnt, rsp_id, rsp_sum, rsp_cout,
                   exp_order[r_cnt], rr_sum[exp_order[r_cnt]], rr_co[exp_order[r_cnt]]);
        end
        r_cnt++;
      end
      tick();
    end
    checks++; if (g_cnt != 5) begin failures++; $display("FAIL rr_grant_count: got %0d expected 5", g_cnt); end
    checks++; if (r_cnt != 4) begin failures++; $display("FAIL rr_rsp_count: got %0d expected 4", r_cnt); end
    for (int i = 0; i < g_cnt; i++) begin
      checks++;
      if (g_id[i] != exp_order[i]) begin failures++; $display("FAIL rr_order_%0d: got %0d expected %0d", i, g_id[i], exp_order[i]); end
      if (i > 0) begin
        checks++;
        if (g_cyc[i] - g_cyc[i-1] != WORDS + 2) begin failures++; $display("FAIL rr_spacing_%0d: got %0d expected %0d", i, g_cyc[i] - g_cyc[i-1], WORDS + 2); end
      end
    end
    for (int i = 0; i < r_cnt && i < g_cnt; i++) begin
      checks++;
      if (r_cyc[i] - g_cyc[i] != WORDS + 1) begin failures++; $display("FAIL rr_latency_%0d: got %0d expected %0d", i, r_cyc[i] - g_cyc[i], WORDS + 1); end
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_hold_done();
    bit ok;
    bit ready_seen = 1'b0;
    set_op(0, 64'h5, 64'h6, 1'b0);
    set_op(2, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL hold_grant0: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0100;
    for (int n = 0; n < 20 && rsp_valid !== 1'b1; n++) begin
      if (req_ready !== 4'b0000) ready_seen = 1'b1;
      tick();
    end
    checks++; if (ready_seen) begin failures++; $display("FAIL hold_grant_in_add: got a grant expected none"); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_timeout: rsp_valid got %b expected 1", rsp_valid); end
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 64'hB || rsp_id !== 2'd0 || rsp_cout !== 1'b0 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL hold_stable_%0d: got valid %b sum %h id %0d cout %b ready %b expected 1 b 0 0 0000", n, rsp_valid, rsp_sum, rsp_id, rsp_cout, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL hold_handshake_ready: got %b expected 0000", req_ready); end
    tick();
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 4'b0100 || busy !== 1'b0) begin failures++; $display("FAIL hold_next_grant: ready %b busy %b expected 0100 0", req_ready, busy); end
    tick();
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_sum !== 64'h1234_5678_9ABC_DF00 || rsp_id !== 2'd2 || rsp_cout !== 1'b0) begin
      failures++;
      $display("FAIL hold_req2_result: got valid %b sum %h id %0d cout %b expected 1 123456789abcdf00 2 0", rsp_valid, rsp_sum, rsp_id, rsp_cout);
    end
    handshake();
  endtask

  task automatic test_reset_mid_add();
    bit ok;
    bit spurious = 1'b0;
    set_op(0, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b0);
    set_op(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rma_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rma_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_sum !== 64'h0) begin failures++; $display("FAIL rma_after_reset: busy %b valid %b sum %h expected 0 0 0", busy, rsp_valid, rsp_sum); end
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rma_priority: got %b expected 0001", req_ready); end
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rma_grant1: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    for (int n = 0; n < WORDS; n++) begin
      if (rsp_valid !== 1'b0) spurious = 1'b1;
      tick();
    end
    checks++; if (spurious) begin failures++; $display("FAIL rma_early_valid: got early rsp_valid expected none"); end
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_sum !== 64'h1 || rsp_cout !== 1'b1 || rsp_id !== 2'd1) begin
      failures++;
      $display("FAIL rma_req1_result: got valid %b sum %h cout %b id %0d expected 1 1 1 1", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    handshake();
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rma_grant0: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_sum !== 64'h0002_0002_0002_0002 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL rma_req0_result: got valid %b sum %h id %0d expected 1 0002000200020002 0", rsp_valid, rsp_sum, rsp_id);
    end
    handshake();
  endtask

  task automatic test_operand_capture();
    bit ok;
    set_op(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL cap_grant: got %b expected 0001", req_ready); end
    tick();
    set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    req_valid = 4'b0000;
    wait_rsp(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cap_timeout: rsp_valid got %b expected 1", rsp_valid); end
    checks++; if (rsp_sum !== 64'h2222_2222_2222_2212) begin failures++; $display("FAIL cap_sum: got %h expected 2222222222222212", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin failures++; $display("FAIL cap_cout: got %b expected 0", rsp_cout); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_carry_chain();
    test_round_robin();
    test_hold_done();
    test_reset_mid_add();
    test_operand_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
